// File: rtl/shift_reg_16.sv
// 16-deep complex delay line feeding the MDC FFT butterfly (pairs sample n with n+16).
// Optional synchronous clear port is enabled by defining SHIFT16_CLR_EN.
module shift_reg_16 #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SHIFT16_CLR_EN
  input  logic             clr,
`endif
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_full
);

  localparam int            CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Handshake: di_en is a one-sided accept strobe with no back-pressure; a sample is
  // taken on every rising clk where di_en = 1, and nothing moves when di_en = 0.

  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] re_d [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];
  logic [WIDTH-1:0] im_d [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             clr_w;

`ifdef SHIFT16_CLR_EN
  assign clr_w = clr;
`else
  assign clr_w = 1'b0;
`endif

  // Clear wins over accept, so a sample presented alongside clr is dropped.
  always_comb begin
    re_d  = re_q;
    im_d  = im_q;
    cnt_d = cnt_q;
    if (clr_w) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_d[k] = '0;
        im_d[k] = '0;
      end
      cnt_d = '0;
    end else if (di_en) begin
      re_d[0] = di_re;
      im_d[0] = di_im;
      for (int k = 1; k < DEPTH; k++) begin
        re_d[k] = re_q[k-1];
        im_d[k] = im_q[k-1];
      end
      if (cnt_q != FULL_CNT) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
      cnt_q <= '0;
    end else begin
      re_q  <= re_d;
      im_q  <= im_d;
      cnt_q <= cnt_d;
    end
  end

  assign do_re   = re_q[DEPTH-1];
  assign do_im   = im_q[DEPTH-1];
  assign do_full = (cnt_q == FULL_CNT);

endmodule

// File: tb/tb_shift_reg_16.sv
// Randomized and directed bench for shift_reg_16 against a queue-based delay-line model.
// Define SHIFT16_CLR_EN for both files to exercise the clear port.
module tb_shift_reg_16;

  localparam int W     = 13;
  localparam int DEPTH = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         di_en = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] di_re = '0;
  logic [W-1:0] di_im = '0;
  logic [W-1:0] do_re;
  logic [W-1:0] do_im;
  logic         do_full;

  always #5 clk = ~clk;

  shift_reg_16 #(.WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef SHIFT16_CLR_EN
    .clr     (clr),
`endif
    .di_en   (di_en),
    .di_re   (di_re),
    .di_im   (di_im),
    .do_re   (do_re),
    .do_im   (do_im),
    .do_full (do_full)
  );

  // ---------------- scoreboard ----------------
  // exp_q holds the last DEPTH accepted {re,im} pairs; once full, its front is what must emerge.
  logic [2*W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [W-1:0] er;
    logic [W-1:0] ei;
    er = '0;
    ei = '0;
    if (exp_q.size() == DEPTH) begin
      er = exp_q[0][2*W-1:W];
      ei = exp_q[0][W-1:0];
    end
    check({tag, "_re"},   32'(do_re),   32'(er));
    check({tag, "_im"},   32'(do_im),   32'(ei));
    check({tag, "_full"}, 32'(do_full), 32'(exp_q.size() == DEPTH));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: drive, take the rising edge, update the model, check at the next negedge.
  task automatic step(input logic en, input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic c, input string tag);
    di_en = en;
    di_re = re;
    di_im = im;
`ifdef SHIFT16_CLR_EN
    clr = c;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    if (clr) begin
      exp_q.delete();
    end else if (en) begin
      exp_q.push_back({re, im});
      if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
    end
    @(negedge clk);
    clr = 1'b0;
    check_outputs(tag);
  endtask

  task automatic feed(input logic [W-1:0] re, input logic [W-1:0] im, input string tag);
    step(1'b1, re, im, 1'b0, tag);
  endtask

  task automatic rand_feed(input int n, input string tag);
    for (int i = 0; i < n; i++)
      feed(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), tag);
  endtask

  // Pulse rst_n mid-cycle and confirm the outputs clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    check({tag, "_re"},   32'(do_re),   32'd0);
    check({tag, "_im"},   32'(do_im),   32'd0);
    check({tag, "_full"}, 32'(do_full), 32'd0);
    @(negedge clk);
    di_en = 1'b0;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int lat_re[10] = '{5, 2, 6, -2, 0, 2, 5, 1, 0, 5};
  int lat_im[10] = '{-3, -1, -3, -1, -3, -6, -5, -1, -1, -3};

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset_hold");
    rst_n = 1'b1;

    // Continuous-enable latency with the directed pattern, then zeros.
    for (int k = 1; k <= 24; k++) begin
      if (k <= 10) feed(W'(lat_re[k-1]), W'(lat_im[k-1]), "latency");
      else         feed('0, '0, "latency");
      if (k == 15) check("lat_e15_re", 32'(do_re), 32'd0);
      if (k == 16) begin
        check("lat_e16_re", 32'(do_re), 32'd5);
        check("lat_e16_im", 32'(do_im), 32'h1FFD);
        check("lat_e16_full", 32'(do_full), 32'd1);
      end
      if (k == 19) begin
        check("lat_e19_re", 32'(do_re), 32'h1FFE);
        check("lat_e19_im", 32'(do_im), 32'h1FFF);
      end
    end

    // Mid-cycle async reset of a full line, then stall during refill.
    async_reset("areset_full");
    for (int k = 1; k <= 21; k++) begin
      if (k > 8 && k <= 13) step(1'b0, W'(k + 100), W'(k + 200), 1'b0, "stall");
      else                  feed(W'(k), W'(k + 50), "stall");
      if (k == 20) check("stall_full_pre", 32'(do_full), 32'd0);
      if (k == 21) begin
        check("stall_full_at16", 32'(do_full), 32'd1);
        check("stall_first_re", 32'(do_re), 32'd1);
      end
    end

    // Full-scale bit patterns must pass unmodified.
    feed(13'h0FFF, 13'h0FFF, "fullscale");
    feed(13'h1000, 13'h1000, "fullscale");
    for (int k = 0; k < DEPTH; k++) begin
      feed(W'(k), W'(~k), "fullscale");
      if (k == 13) begin
        check("fs_pos_re", 32'(do_re), 32'h0FFF);
        check("fs_pos_im", 32'(do_im), 32'h0FFF);
      end
      if (k == 14) begin
        check("fs_neg_re", 32'(do_re), 32'h1000);
        check("fs_neg_im", 32'(do_im), 32'h1000);
      end
    end

    // Reset after 10 accepted samples, then refill.
    async_reset("areset_pre");
    rand_feed(10, "midstream");
    async_reset("areset_mid");
    rand_feed(20, "refill");

`ifdef SHIFT16_CLR_EN
    // Clear together with an accept: the same-cycle sample must not be stored.
    step(1'b1, 13'h0ABC, 13'h0123, 1'b1, "clr");
    check("clr_full", 32'(do_full), 32'd0);
    check("clr_re", 32'(do_re), 32'd0);
    feed(13'h0777, 13'h1555, "after_clr");
    rand_feed(15, "after_clr");
    check("clr_next_re", 32'(do_re), 32'h0777);
    check("clr_next_im", 32'(do_im), 32'h1555);
`endif

    // Random accept pattern with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      logic en;
      logic c;
      en = ($urandom_range(0, 3) != 0);
      c  = ($urandom_range(0, 59) == 0);
      step(en, W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
           c, "random");
      if ($urandom_range(0, 149) == 0) async_reset("areset_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
